// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0] PC_STEP          = 64'd4;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 64'h0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  // One buffered fetch: the address it came from and the word read there.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instructions are word aligned; the low two address bits must be zero.
  function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO buffering fetched {pc, instr} entries
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop never underflows; a push into a full buffer is legal only when
  // the head retires on the same edge and frees its slot.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);

  assign head = mem[rd_ptr];

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC sequencing, redirect/fault handling and fetch buffering
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [63:0] Inst_Address,
  input  logic [31:0] instruction,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        fault,
  output logic [63:0] fault_pc
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;
  logic              push;
  logic              pop;
  logic              flush;
  fetch_entry_t      push_data;
  fetch_entry_t      head;
  logic [CNT_W-1:0]  fifo_count;

  assign Inst_Address = pc_q;
  assign push_data    = '{pc: pc_q, instr: instruction};
  assign out_valid    = (fifo_count != '0);
  assign pop          = out_valid && out_ready;
  assign out_instr    = out_valid ? head.instr : '0;
  assign out_pc       = out_valid ? head.pc : '0;
  assign fault        = (state_q == ST_FAULT);
  assign fault_pc     = fault_pc_q;

  // Next-state logic: redirects win over sequential fetch in every state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    if (redirect_valid) begin
      flush = 1'b1;
      if (!is_aligned(redirect_pc)) begin
        fault_pc_d = redirect_pc;
        state_d    = ST_FAULT;
      end else begin
        pc_d = redirect_pc;
        if (state_q == ST_FAULT) begin
          state_d = ST_RUN;
        end
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if ((fifo_count != FULL) || pop) begin
            push = 1'b1;
            pc_d = pc_q + PC_STEP;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, PC and captured fault address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .flush    (flush),
    .head     (head),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;
  import fetch_pkg::*;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  localparam logic [7:0] MEM_BYTES [16] = '{
    8'h83, 8'h34, 8'h85, 8'h02, 8'hB3, 8'h84, 8'h9A, 8'h00,
    8'h93, 8'h84, 8'h14, 8'h00, 8'h23, 8'h34, 8'h95, 8'h02
  };

  logic        clk = 1'b0;
  logic        reset, start, redirect_valid, out_ready;
  logic [63:0] redirect_pc;
  logic [63:0] addr1, addr2, opc1, opc2, fpc1, fpc2;
  logic [31:0] instr1, instr2, oin1, oin2;
  logic        ov1, ov2, f1, f2;
  logic        sel2;
  logic        m_valid;
  logic [63:0] m_pc;
  logic [31:0] m_instr;

  int   checks   = 0;
  int   failures = 0;
  exp_t sbq[$];
  exp_t vec_tab [4];

  always #5 clk = ~clk;

  // Little-endian instruction memory; outside the image, a distinct pattern per address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    int i;
    if (a < 64'd16) begin
      i = int'(a[3:0]);
      return {MEM_BYTES[i+3], MEM_BYTES[i+2], MEM_BYTES[i+1], MEM_BYTES[i]};
    end
    return a[31:0] ^ 32'h5A5A_5A5A;
  endfunction

  assign instr1  = mem_word(addr1);
  assign instr2  = mem_word(addr2);
  assign m_valid = sel2 ? ov2 : ov1;
  assign m_pc    = sel2 ? opc2 : opc1;
  assign m_instr = sel2 ? oin2 : oin1;

  instruction_fetch #(.RESET_PC(64'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .start(start), .Inst_Address(addr1), .instruction(instr1),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(ov1),
    .out_ready(out_ready), .out_instr(oin1), .out_pc(opc1), .fault(f1), .fault_pc(fpc1)
  );

  instruction_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
    .clk(clk), .reset(reset), .start(start), .Inst_Address(addr2), .instruction(instr2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(ov2),
    .out_ready(out_ready), .out_instr(oin2), .out_pc(opc2), .fault(f2), .fault_pc(fpc2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at a falling edge; compares every accepted head against the queue.
  task automatic run_expect(input int n, input int budget);
    int   got = 0;
    exp_t e;
    for (int c = 0; c < budget && got < n; c++) begin
      if (m_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_pop", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("sb_out_pc", m_pc, e.pc);
          chk("sb_out_instr", 64'(m_instr), 64'(e.instr));
        end
        got++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk("sb_drained", 64'(got), 64'(n));
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    start          = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_redirect(input logic [63:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_tab[0] = '{pc: 64'd0,  instr: 32'h0285_3483};
    vec_tab[1] = '{pc: 64'd4,  instr: 32'h009A_84B3};
    vec_tab[2] = '{pc: 64'd8,  instr: 32'h0014_8493};
    vec_tab[3] = '{pc: 64'd12, instr: 32'h0295_3423};

    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    out_ready = 1'b0; sel2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset values
    chk("rst_out_valid", 64'(ov1), 64'd0);
    chk("rst_out_instr", 64'(oin1), 64'd0);
    chk("rst_out_pc", opc1, 64'd0);
    chk("rst_inst_address", addr1, 64'd0);
    chk("rst_fault", 64'(f1), 64'd0);
    chk("rst_fault_pc", fpc1, 64'd0);
    chk("rst_inst_address_wrap", addr2, 64'hFFFF_FFFF_FFFF_FFF8);

    // Streaming fetch with decode always ready
    for (int i = 0; i < 4; i++) sbq.push_back(vec_tab[i]);
    reset = 1'b0;
    out_ready = 1'b1;
    pulse_start();
    run_expect(4, 20);

    // Backpressure fills the buffer, then drains in order
    do_reset();
    pulse_start();
    repeat (5) @(negedge clk);
    chk("stall_inst_address", addr1, 64'd8);
    chk("stall_out_valid", 64'(ov1), 64'd1);
    chk("stall_out_instr", 64'(oin1), 64'h0285_3483);
    chk("stall_out_pc", opc1, 64'd0);
    for (int i = 0; i < 4; i++) sbq.push_back(vec_tab[i]);
    out_ready = 1'b1;
    run_expect(4, 20);

    // Redirect with two entries buffered flushes them
    do_reset();
    pulse_start();
    repeat (2) @(negedge clk);
    chk("pre_redirect_inst_address", addr1, 64'd8);
    do_redirect(64'hC);
    chk("redirect_flush_valid", 64'(ov1), 64'd0);
    chk("redirect_inst_address", addr1, 64'hC);
    @(negedge clk);
    chk("redirect_head_valid", 64'(ov1), 64'd1);
    chk("redirect_head_pc", opc1, 64'hC);
    chk("redirect_head_instr", 64'(oin1), 64'h0295_3423);
    chk("redirect_next_address", addr1, 64'h10);

    // Misaligned redirect enters FAULT; start ignored; aligned redirect recovers
    do_reset();
    do_redirect(64'h6);
    chk("fault_set", 64'(f1), 64'd1);
    chk("fault_pc_captured", fpc1, 64'h6);
    chk("fault_out_valid", 64'(ov1), 64'd0);
    chk("fault_pc_unchanged", addr1, 64'd0);
    out_ready = 1'b1;
    pulse_start();
    @(negedge clk);
    chk("fault_start_ignored", 64'(f1), 64'd1);
    chk("fault_no_push", 64'(ov1), 64'd0);
    chk("fault_addr_hold", addr1, 64'd0);
    do_redirect(64'h4);
    chk("fault_cleared", 64'(f1), 64'd0);
    chk("recover_inst_address", addr1, 64'h4);
    sbq.push_back('{pc: 64'h4, instr: 32'h009A_84B3});
    sbq.push_back('{pc: 64'h8, instr: 32'h0014_8493});
    run_expect(2, 10);

    // Aligned redirect while idle moves the PC but does not start fetching
    do_reset();
    do_redirect(64'h8);
    chk("idle_redirect_addr", addr1, 64'h8);
    repeat (2) @(negedge clk);
    chk("idle_redirect_no_push", 64'(ov1), 64'd0);
    chk("idle_redirect_fault", 64'(f1), 64'd0);
    out_ready = 1'b1;
    sbq.push_back('{pc: 64'h8, instr: 32'h0014_8493});
    sbq.push_back('{pc: 64'hC, instr: 32'h0295_3423});
    pulse_start();
    run_expect(2, 10);

    // PC wraps modulo 2^64 without faulting
    do_reset();
    sel2 = 1'b1;
    out_ready = 1'b1;
    sbq.push_back('{pc: 64'hFFFF_FFFF_FFFF_FFF8, instr: mem_word(64'hFFFF_FFFF_FFFF_FFF8)});
    sbq.push_back('{pc: 64'hFFFF_FFFF_FFFF_FFFC, instr: mem_word(64'hFFFF_FFFF_FFFF_FFFC)});
    sbq.push_back('{pc: 64'h0, instr: 32'h0285_3483});
    sbq.push_back('{pc: 64'h4, instr: 32'h009A_84B3});
    pulse_start();
    run_expect(4, 20);
    chk("wrap_no_fault", 64'(f2), 64'd0);
    sel2 = 1'b0;

    // Reset beats a concurrent redirect, start and handshake
    do_reset();
    pulse_start();
    repeat (2) @(negedge clk);
    chk("pre_reset_valid", 64'(ov1), 64'd1);
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h10; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0; redirect_valid = 1'b0; start = 1'b0;
    chk("midreset_out_valid", 64'(ov1), 64'd0);
    chk("midreset_inst_address", addr1, 64'd0);
    chk("midreset_fault", 64'(f1), 64'd0);
    repeat (2) @(negedge clk);
    chk("midreset_idle_no_push", 64'(ov1), 64'd0);
    chk("midreset_idle_addr", addr1, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0, address loaded into PC by reset.
REQ-002 Parameter FIFO_DEPTH, default 2, fetch-buffer entries, power of two, 2..8.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse leaving IDLE and beginning fetch.
REQ-006 Inst_Address  output  64  byte address to instruction memory.
REQ-007 instruction  input  32  little-endian word returned combinationally, same cycle, for Inst_Address.
REQ-008 redirect_valid  input  1  branch/jump redirect request.
REQ-009 redirect_pc  input  64  redirect target byte address.
REQ-010 out_valid  output  1  fetch-buffer head valid toward decode.
REQ-011 out_ready  input  1  decode accepts head.
REQ-012 out_instr  output  32  head instruction word.
REQ-013 out_pc  output  64  head instruction address.
REQ-014 fault  output  1  misaligned-PC fault, level, held until cleared.
REQ-015 fault_pc  output  64  offending address captured at fault entry.

Function
REQ-016 States: IDLE, RUN, FAULT; reset -> IDLE.
REQ-017 IDLE -> RUN on start; IDLE issues no pushes.
REQ-018 Inst_Address SHALL equal pc_q continuously in every state.
REQ-019 RUN push: {pc_q, instruction} written to FIFO tail and pc_q += 4, when count < FIFO_DEPTH, or count == FIFO_DEPTH with pop same cycle.
REQ-020 Pop: out_valid && out_ready; head retires that edge.
REQ-021 Fetch latency: word at address A visible on out_* the cycle after pc_q == A is pushed.
REQ-022 out_valid == (count != 0); out_* stable while out_valid && !out_ready.
REQ-023 PC arithmetic modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0 without fault.
REQ-024 redirect_valid has priority over push: FIFO flushed (count=0), pc_q <= redirect_pc, no push that cycle; a concurrent pop still completes handshake.
REQ-025 Redirect in IDLE updates pc_q, stays IDLE.
REQ-026 Redirect with redirect_pc[1:0] != 0 (any state): FIFO flushed, fault=1, fault_pc=redirect_pc, pc_q unchanged, -> FAULT.
REQ-027 FAULT: no pushes; out_valid=0; leaves only on aligned redirect -> RUN at redirect_pc, fault=0 same edge; start ignored.
REQ-028 start while RUN or FAULT ignored.

Reset
REQ-029 Reset: pc_q=RESET_PC, state=IDLE, count=0, FIFO pointers=0, fault=0, fault_pc=0.
REQ-030 Reset values: out_valid=0, out_instr=0, out_pc=0, Inst_Address=RESET_PC.
REQ-031 Reset overrides start, redirect and handshake in the same cycle; mid-stream reset discards buffered words.

Structure
REQ-032 Package fetch_pkg holds state enum, ADDR_W=64, INSTR_W=32, PC_STEP=4, default RESET_PC.
REQ-033 Sub-module fetch_fifo (sync FIFO, {pc,instr} entries, push/pop/flush, count) is instantiated once.

Verification
REQ-034 Memory bytes 0..15 = 83 34 85 02 B3 84 9A 00 93 84 14 00 23 34 95 02, reset, start, out_ready=1 -> out_instr 0x02853483, 0x009A84B3, 0x00148493, 0x02953423 on consecutive cycles with out_pc 0,4,8,12.
REQ-035 out_ready=0 for 5 cycles after start -> exactly FIFO_DEPTH (2) pushes, pc_q=8, out_instr holds 0x02853483; release -> order preserved, no loss.
REQ-036 Redirect to 0xC while 2 entries buffered -> next cycle count=0, then out_pc=0xC, out_instr=0x02953423.
REQ-037 Redirect to 0x6 -> fault=1, fault_pc=0x6, out_valid=0; later redirect to 0x4 -> fault=0, out_instr 0x009A84B3.
REQ-038 RESET_PC=64'hFFFF_FFFF_FFFF_FFF8 -> out_pc ...FFF8, ...FFFC, 0x0 with no fault.
REQ-039 Reset asserted with 2 buffered entries and pending redirect -> next cycle IDLE, out_valid=0, pc_q=RESET_PC.
